// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held per bus cycle
// and a per-transfer timeout that returns err to the owning master.
module wb_master_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   output logic [1:0]      grant_o,
   output logic            timeout_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    grant_q, grant_d;
   logic          own1;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   assign grant_o = grant_q;
   assign own1    = (state_q == OWN1);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      grant_d   = grant_q;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_sel_o   = '0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m0_dat_o  = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_dat_o  = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      timeout_o = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            grant_d = '0;
            // last_q==1 means m1 was served most recently, so m0 wins a tie
            if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
               state_d = OWN0;
               grant_d = 2'b01;
               last_d  = 1'b0;
            end else if (m1_cyc_i) begin
               state_d = OWN1;
               grant_d = 2'b10;
               last_d  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            s_cyc_o  = own1 ? m1_cyc_i : m0_cyc_i;
            s_stb_o  = own1 ? m1_stb_i : m0_stb_i;
            s_we_o   = own1 ? m1_we_i  : m0_we_i;
            s_sel_o  = own1 ? m1_sel_i : m0_sel_i;
            s_adr_o  = own1 ? m1_adr_i : m0_adr_i;
            s_dat_o  = own1 ? m1_dat_i : m0_dat_i;
            m0_ack_o = !own1 && s_ack_i;
            m1_ack_o = own1 && s_ack_i;
            m0_dat_o = own1 ? '0 : s_dat_i;
            m1_dat_o = own1 ? s_dat_i : '0;
            if (!s_cyc_o) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (s_stb_o && !s_ack_i) begin
               if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_d = ERR;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end
         ERR: begin
            timeout_o = 1'b1;
            m0_err_o  = grant_q[0];
            m1_err_o  = grant_q[1];
            state_d   = IDLE;
            grant_d   = '0;
            cnt_d     = '0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

endmodule
